// File: rtl/mcs_io_wb_bridge_pkg.sv
// Shared definitions for the MCS IO-bus to Wishbone classic bridge.
package mcs_io_wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int unsigned WB_ADR_SHIFT     = 2;

  // MCS issues byte addresses; the Wishbone side is word addressed.
  function automatic logic [31:0] wb_word_addr(input logic [31:0] byte_addr);
    return byte_addr >> WB_ADR_SHIFT;
  endfunction

endpackage

// File: rtl/mcs_io_wb_bridge.sv
// MicroBlaze MCS IO bus to single Wishbone classic-cycle master, with a bus
// timeout so an unmapped address always completes back to the CPU.
module mcs_io_wb_bridge
  import mcs_io_wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IO_Addr_Strobe,
  input  logic        IO_Read_Strobe,
  input  logic        IO_Write_Strobe,
  input  logic [31:0] IO_Address,
  input  logic [3:0]  IO_Byte_Enable,
  input  logic [31:0] IO_Write_Data,
  output logic [31:0] IO_Read_Data,
  output logic        IO_Ready,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        adr_q, adr_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        dat_q, dat_d;
  logic               we_q, we_d;
  logic               cyc_q, cyc_d;
  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               bus_err_q, bus_err_d;

  logic accept_c;
  logic timeout_c;

  assign accept_c  = IO_Addr_Strobe & (IO_Read_Strobe ^ IO_Write_Strobe);
  // Counter is loaded with TIMEOUT on entry; this is the cycle it reaches zero.
  assign timeout_c = (cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_BUS;
      ST_BUS:  if (wb_err_i || wb_ack_i || timeout_c) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; err outranks ack, ack outranks timeout.
  always_comb begin
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    ready_d   = 1'b0;
    rdata_d   = 32'd0;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          adr_d = wb_word_addr(IO_Address);
          sel_d = IO_Byte_Enable;
          dat_d = IO_Write_Data;
          we_d  = IO_Write_Strobe;
          cnt_d = CNT_W'(TIMEOUT);
          cyc_d = 1'b1;
        end
      end
      ST_BUS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (wb_err_i || (!wb_ack_i && timeout_c)) begin
          cyc_d     = 1'b0;
          ready_d   = 1'b1;
          rdata_d   = ERR_DATA;
          bus_err_d = 1'b1;
        end else if (wb_ack_i) begin
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          rdata_d = we_q ? 32'd0 : wb_dat_i;
        end
      end
      default: ;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q     <= '0;
      adr_q     <= 32'd0;
      sel_q     <= 4'd0;
      dat_q     <= 32'd0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign IO_Ready     = ready_q;
  assign IO_Read_Data = rdata_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = sel_q;
  assign wb_dat_o     = dat_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mcs_io_wb_bridge.sv
// Directed plus randomized bench for mcs_io_wb_bridge against a latency/data model.
module tb_mcs_io_wb_bridge;

  localparam int unsigned TO = 255;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_NONE = 2;
  localparam int K_BOTH = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        IO_Addr_Strobe = 1'b0;
  logic        IO_Read_Strobe = 1'b0;
  logic        IO_Write_Strobe = 1'b0;
  logic [31:0] IO_Address = 32'd0;
  logic [3:0]  IO_Byte_Enable = 4'd0;
  logic [31:0] IO_Write_Data = 32'd0;
  logic [31:0] IO_Read_Data;
  logic        IO_Ready;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'd0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  bit err_model = 1'b0;

  mcs_io_wb_bridge #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .Clk(Clk), .Reset(Reset),
    .IO_Addr_Strobe(IO_Addr_Strobe), .IO_Read_Strobe(IO_Read_Strobe),
    .IO_Write_Strobe(IO_Write_Strobe), .IO_Address(IO_Address),
    .IO_Byte_Enable(IO_Byte_Enable), .IO_Write_Data(IO_Write_Data),
    .IO_Read_Data(IO_Read_Data), .IO_Ready(IO_Ready),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .bus_err(bus_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One MCS access; the slave answers after w wait states with the given kind.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input logic [31:0] rdata,
                     input int w, input int kind);
    int lat;
    logic [31:0] exp_data;
    @(posedge Clk); #1;
    chk("ready_before", 32'(IO_Ready), 32'd0);
    lat = (kind == K_NONE) ? int'(TO) + 1 : w + 2;
    exp_data = (kind != K_ACK) ? ERRD : (wr ? 32'd0 : rdata);
    if (kind != K_ACK) err_model = 1'b1;
    IO_Addr_Strobe  = 1'b1;
    IO_Read_Strobe  = !wr;
    IO_Write_Strobe = wr;
    IO_Address      = addr;
    IO_Byte_Enable  = be;
    IO_Write_Data   = wdata;
    for (int c = 1; c <= lat; c++) begin
      @(posedge Clk); #1;
      IO_Addr_Strobe  = 1'b0;
      IO_Read_Strobe  = 1'b0;
      IO_Write_Strobe = 1'b0;
      IO_Write_Data   = $urandom;
      if (c == 1) begin
        chk("wb_adr", wb_adr_o, {2'b00, addr[31:2]});
        chk("wb_sel", 32'(wb_sel_o), 32'(be));
        chk("wb_we", 32'(wb_we_o), 32'(wr));
        chk("wb_dat", wb_dat_o, wdata);
      end
      chk("io_ready", 32'(IO_Ready), 32'(c == lat));
      chk("wb_cyc", 32'(wb_cyc_o), 32'(c < lat));
      chk("wb_stb", 32'(wb_stb_o), 32'(c < lat));
      chk("io_rdata", IO_Read_Data, (c == lat) ? exp_data : 32'd0);
      if (c == lat) chk("bus_err", 32'(bus_err), 32'(err_model));
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      if (wb_cyc_o && (c - 1 == w)) begin
        case (kind)
          K_ACK:  begin wb_ack_i = 1'b1; wb_dat_i = rdata; end
          K_ERR:  begin wb_err_i = 1'b1; wb_ack_i = 1'($urandom_range(0, 1)); end
          K_BOTH: begin wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = rdata; end
          default: ;
        endcase
      end
      if (IO_Ready) break;
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
  endtask

  // Malformed strobe combination must be ignored.
  task automatic bad_strobe(input bit rd, input bit wr);
    @(posedge Clk); #1;
    IO_Addr_Strobe  = 1'b1;
    IO_Read_Strobe  = rd;
    IO_Write_Strobe = wr;
    IO_Address      = $urandom;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      IO_Addr_Strobe  = 1'b0;
      IO_Read_Strobe  = 1'b0;
      IO_Write_Strobe = 1'b0;
      chk("ign_cyc", 32'(wb_cyc_o), 32'd0);
      chk("ign_ready", 32'(IO_Ready), 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ready", 32'(IO_Ready), 32'd0);
    chk("rst_rdata", IO_Read_Data, 32'd0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    Reset = 1'b0;

    txn(1'b1, 32'hC000_0010, 4'hF, 32'h1234_5678, 32'd0, 0, K_ACK);
    txn(1'b0, 32'hC000_0004, 4'hF, 32'd0, 32'hCAFE_F00D, 3, K_ACK);
    bad_strobe(1'b0, 1'b0);
    bad_strobe(1'b1, 1'b1);
    txn(1'b1, 32'h0000_0102, 4'b0100, 32'h00AB_0000, 32'd0, 1, K_ACK);
    txn(1'b0, 32'h0000_0100, 4'hF, 32'd0, 32'h5566_7788, 0, K_ACK);

    for (int i = 0; i < 12; i++)
      txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, $urandom,
          int'($urandom_range(0, 5)), K_ACK);

    txn(1'b0, 32'hF000_0000, 4'hF, 32'd0, 32'd0, 0, K_NONE);
    txn(1'b1, 32'hC000_0020, 4'hF, 32'h0BAD_0BAD, 32'h1111_2222, 2, K_BOTH);

    for (int i = 0; i < 8; i++)
      txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, $urandom,
          int'($urandom_range(0, 4)), ($urandom_range(0, 2) == 0) ? K_ERR : K_ACK);

    // Reset while the access is in flight.
    @(posedge Clk); #1;
    IO_Addr_Strobe = 1'b1; IO_Read_Strobe = 1'b1; IO_Address = 32'hC000_0040;
    @(posedge Clk); #1;
    IO_Addr_Strobe = 1'b0; IO_Read_Strobe = 1'b0;
    @(posedge Clk); #1;
    chk("pre_rst_cyc", 32'(wb_cyc_o), 32'd1);
    Reset = 1'b1;
    #1;
    err_model = 1'b0;
    chk("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    chk("mid_rst_ready", 32'(IO_Ready), 32'd0);
    chk("mid_rst_adr", wb_adr_o, 32'd0);
    chk("mid_rst_bus_err", 32'(bus_err), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      chk("post_rst_ready", 32'(IO_Ready), 32'd0);
      chk("post_rst_cyc", 32'(wb_cyc_o), 32'd0);
    end
    txn(1'b0, 32'hC000_0008, 4'hF, 32'd0, 32'h7E57_0001, 2, K_ACK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
